// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one 4x4 unsigned multiplier among NREQ requesters,
// with a one-entry tagged result register released under valid/ready.

module pfx_add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s
);
  logic [7:0] w_h, w_g0, w_g1, w_g2, w_g3, w_p1, w_p2;

  // Kogge-Stone: generate/propagate spans double each level (1, 2, 4)
  assign w_h  = a ^ b;
  assign w_g0 = a & b;
  assign w_g1 = w_g0 | (w_h  & {w_g0[6:0], 1'b0});
  assign w_p1 = w_h  & {w_h[6:0], 1'b1};
  assign w_g2 = w_g1 | (w_p1 & {w_g1[5:0], 2'b0});
  assign w_p2 = w_p1 & {w_p1[5:0], 2'b11};
  assign w_g3 = w_g2 | (w_p2 & {w_g2[3:0], 4'b0});
  assign s    = w_h ^ {w_g3[6:0], 1'b0};
endmodule

module main (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);
  logic [7:0] w_pp0, w_pp1, w_pp2, w_pp3, w_s01, w_s23;

  assign w_pp0 = {4'b0, x & {4{y[0]}}};
  assign w_pp1 = {3'b0, x & {4{y[1]}}, 1'b0};
  assign w_pp2 = {2'b0, x & {4{y[2]}}, 2'b0};
  assign w_pp3 = {1'b0, x & {4{y[3]}}, 3'b0};

  // Two-level tree; carry-out is never needed since 15*15 fits in 8 bits
  pfx_add8 u_a01 (.a(w_pp0), .b(w_pp1), .s(w_s01));
  pfx_add8 u_a23 (.a(w_pp2), .b(w_pp3), .s(w_s23));
  pfx_add8 u_fin (.a(w_s01), .b(w_s23), .s(p));
endmodule

module mult_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [4*NREQ-1:0]    req_x,
  input  logic [4*NREQ-1:0]    req_y,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_data,
  output logic [TAGW-1:0]      res_tag,
  output logic [15:0]          op_count
);
  logic [TAGW-1:0] r_ptr, r_res_tag;
  logic            r_res_valid;
  logic [7:0]      r_res_data;
  logic [15:0]     r_op_count;

  logic                      w_free, w_hit;
  logic [NREQ-1:0]           w_one, w_mask, w_hi, w_sel, w_grant;
  logic [TAGW-1:0][NREQ-1:0] w_bm;
  logic [TAGW-1:0]           w_gidx, w_ptr_nxt;
  logic [4*NREQ-1:0]         w_xs, w_ys;
  logic [3:0]                w_x, w_y;
  logic [7:0]                w_prod;

  assign w_free = !r_res_valid || res_ready;

  // Prefer valid requesters at or above ptr; otherwise wrap to the lowest valid one
  assign w_one   = {{(NREQ-1){1'b0}}, 1'b1};
  assign w_mask  = ~((w_one << r_ptr) - w_one);
  assign w_hi    = req_valid & w_mask;
  assign w_sel   = (|w_hi) ? w_hi : req_valid;
  assign w_grant = w_free ? (w_sel & (~w_sel + w_one)) : '0;
  assign w_hit   = |w_grant;

  genvar b, i;
  generate
    for (b = 0; b < TAGW; b++) begin : g_enc
      for (i = 0; i < NREQ; i++) begin : g_bit
        assign w_bm[b][i] = (((i >> b) % 2) == 1);
      end
      assign w_gidx[b] = |(w_grant & w_bm[b]);
    end
  endgenerate

  assign w_ptr_nxt = (w_gidx == TAGW'(NREQ-1)) ? '0 : w_gidx + 1'b1;

  assign w_xs = req_x >> {w_gidx, 2'b00};
  assign w_ys = req_y >> {w_gidx, 2'b00};
  assign w_x  = w_xs[3:0] & {4{w_hit}};
  assign w_y  = w_ys[3:0] & {4{w_hit}};

  main u_mul (.x(w_x), .y(w_y), .p(w_prod));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
      r_op_count  <= '0;
    end else begin
      if (w_hit) begin
        r_res_data  <= w_prod;
        r_res_tag   <= w_gidx;
        r_res_valid <= 1'b1;
        r_ptr       <= w_ptr_nxt;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
      if (r_res_valid && res_ready)
        r_op_count <= r_op_count + 16'd1;
    end
  end

  assign req_ready = w_grant;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_tag   = r_res_tag;
  assign op_count  = r_op_count;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scoreboard bench: the driver predicts grants and queues expected results; a monitor
// pops and compares them on every result handshake.
module tb_mult_rr_scheduler;
  localparam int N  = 4;
  localparam int TW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [4*N-1:0]  req_x = '0, req_y = '0;
  logic [N-1:0]    req_ready;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [7:0]      res_data;
  logic [TW-1:0]   res_tag;
  logic [15:0]     op_count;

  mult_rr_scheduler #(.NREQ(N), .TAGW(TW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int sb[$];
  bit m_valid = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Inputs change 1 time unit after the edge; the model is evaluated 3 units later
  task automatic step(input logic [N-1:0] v, input logic [4*N-1:0] xs, input logic [4*N-1:0] ys,
                      input logic rr, input logic r);
    int g;
    logic [N-1:0] t;
    logic [4*N-1:0] sx, sy;
    @(posedge clk); #1;
    req_valid = v; req_x = xs; req_y = ys; res_ready = rr; rst = r;
    #3;
    g = -1;
    if (!m_valid || rr)
      for (int k = 0; k < N; k++) begin
        t = v >> ((m_ptr + k) % N);
        if (g < 0 && t[0]) g = (m_ptr + k) % N;
      end
    chk("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
    if (r) begin
      sb.delete(); m_valid = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (m_valid && rr) begin m_valid = 0; m_cnt++; end
      if (g >= 0) begin
        sx = xs >> (4*g);
        sy = ys >> (4*g);
        sb.push_back(g*256 + int'(sx[3:0]) * int'(sy[3:0]));
        m_valid = 1;
        m_ptr = (g + 1) % N;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #3;
      chk("res_valid", int'(res_valid), int'(m_valid));
      chk("op_count", int'(op_count), m_cnt % 65536);
      if (m_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL scoreboard: result visible with no expected entry at %0t", $time);
        end else begin
          chk("res_data", int'(res_data), sb[0] % 256);
          chk("res_tag", int'(res_tag), sb[0] / 256);
          if (res_ready && !rst) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [4*N-1:0] xs, ys;
    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b1);

    // single request 3*5 from requester 0
    step(4'b0001, 16'h0003, 16'h0005, 1'b1, 1'b0);
    step('0, '0, '0, 1'b1, 1'b0);
    step('0, '0, '0, 1'b1, 1'b0);

    // all valid from ptr=0: tags 0..3 repeating, no idle cycles
    step('0, '0, '0, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) step(4'b1111, 16'hFEDC, 16'hFFFF, 1'b1, 1'b0);

    // backpressure: slot full for 5 cycles, then drain and accept together
    for (int c = 0; c < 5; c++) step(4'b1111, 16'h4321, 16'h9876, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b1111, 16'h4321, 16'h9876, 1'b1, 1'b0);

    // exhaustive sweep through requester 2
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        xs = 16'($urandom); ys = 16'($urandom);
        xs[11:8] = 4'(x); ys[11:8] = 4'(y);
        step(4'b0100, xs, ys, 1'b1, 1'b0);
      end
    step('0, '0, '0, 1'b1, 1'b0);

    // reset while full, stalled, and requests pending; then lowest valid wins
    step(4'b1111, 16'h1234, 16'h5678, 1'b0, 1'b0);
    step(4'b1111, 16'h1234, 16'h5678, 1'b0, 1'b0);
    step(4'b1111, 16'h1234, 16'h5678, 1'b0, 1'b1);
    step(4'b0110, 16'h0A50, 16'h0B70, 1'b1, 1'b0);
    step('0, '0, '0, 1'b1, 1'b0);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++)
      step(4'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));

    // op_count wrap: 65536 handshakes from reset, passing 0xFFFE, 0xFFFF, 0x0000
    step('0, '0, '0, 1'b1, 1'b1);
    for (int c = 0; c < 65536; c++)
      step(4'b1111, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    step('0, '0, '0, 1'b1, 1'b0);
    step('0, '0, '0, 1'b1, 1'b0);

    @(posedge clk); #4;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
